fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller for the processor's 1024 x 32-bit instruction ROM. It owns the program counter, drives the ROM's combinational read address, registers the returned word into a single-entry output stage, and presents it to decode with a valid/ready handshake. It also handles redirects (branch/jump), halt/resume and stall back-pressure. Sits between the instruction ROM and the decode stage of the core.

## Interface
- ADDR_W, 10, ROM address width (1024 words)
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded at reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- rom_address  output  ADDR_W  ROM read address, combinationally equal to pc
- rom_inst  input  DATA_W  ROM read data (combinational ROM, same-cycle valid)
- inst  output  DATA_W  registered instruction to decode
- inst_pc  output  ADDR_W  address that inst was fetched from
- inst_valid  output  1  inst/inst_pc hold a valid instruction
- inst_ready  input  1  decode accepts inst this cycle
- redirect_valid  input  1  one-cycle request to restart fetch at redirect_target
- redirect_target  input  ADDR_W  new fetch address
- halt_req  input  1  stop fetching (level or pulse)
- halted  output  1  high while in HALT state
- wrapped  output  1  sticky: pc has rolled over from 2^ADDR_W-1 to 0 since reset
- fetch_count  output  16  number of completed handshakes (inst_valid & inst_ready), wraps modulo 2^16

## Operation
- Reset (rst_n low, asynchronous): pc=RESET_PC, state=RUN, inst_valid=0, inst=0, inst_pc=0, halted=0, wrapped=0, fetch_count=0.
- States: RUN, HALT. halted = (state==HALT).
- slot_free = !inst_valid | inst_ready.
- RUN, no redirect, slot_free: inst<=rom_inst, inst_pc<=pc, inst_valid<=1, pc<=pc+1 (mod 2^ADDR_W); on 2^ADDR_W-1 -> 0, wrapped<=1.
- RUN, no redirect, !slot_free (stall): pc, inst, inst_pc, inst_valid hold; rom_address stays at pc.
- redirect_valid (any state): pc<=redirect_target; inst_valid<=0 (flush, even if the slot was stalled); no capture that cycle; state<=RUN unless halt_req is also high. The handshake completing in that cycle (inst_valid & inst_ready) still counts.
- halt_req in RUN, no redirect: state<=HALT; no capture, pc holds; inst_valid<=0 if inst_ready, else holds (the pending instruction remains presentable and is delivered normally).
- HALT: no fetch, pc frozen. A pending inst_valid is cleared on its handshake. Exit only via redirect_valid with halt_req low -> RUN at redirect_target. halt_req high in HALT: no effect.
- redirect_valid & halt_req same cycle: pc<=redirect_target, flush, state<=HALT.
- fetch_count increments on every cycle with inst_valid & inst_ready, in any state.
- Width rule: pc increment is ADDR_W-bit modular, and redirect_target is used unmodified.

## Timing
- rom_address = pc, combinational; the ROM word is captured on the same edge.
- Fetch latency: instruction at pc visible on inst one edge after pc is presented in RUN with slot_free.
- Throughput: 1 instruction/cycle with inst_ready held high.
- Redirect penalty: redirect at edge N -> inst_valid=0 after N -> ROM[target] valid after edge N+1.
- First valid after reset release: ROM[RESET_PC] after the first rising edge with rst_n high.
- All outputs except rom_address are registered. rst_n assertion clears state without waiting for clk.

## Test plan
- Reset then inst_ready=1 for 5 cycles, ROM[i]=i+0x100 -> inst=0x100..0x104, inst_pc=0..4, fetch_count=5, no bubbles.
- inst_ready low for 3 cycles while inst_pc=2 -> inst/inst_pc stable at ROM[2]/2, rom_address stays 3; on ready, the sequence resumes at 3 with no skip or duplicate.
- redirect_valid with target 0x200 during a stall at inst_pc=7 -> inst_valid=0 next cycle, then inst_pc=0x200 and 0x201 on consecutive cycles; fetch_count excludes 7.
- Redirect to 0x3FE with ready=1 -> inst_pc 0x3FE, 0x3FF, 0x000, 0x001; wrapped rises after 0x3FF is captured and stays high.
- halt_req while inst_valid=1 and inst_ready=0 -> halted=1, pending inst delivered when ready rises, then inst_valid=0 and pc frozen; redirect to 0x10 -> halted=0, inst_pc=0x10 next.
- Assert rst_n low mid-stream at inst_pc=0x55 -> all outputs clear immediately; after release, inst_pc=RESET_PC first.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM and
// presents one registered instruction to decode with valid/ready, redirect and halt.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_inst,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic              halted,
  output logic              wrapped,
  output logic [15:0]       fetch_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              valid_q, valid_d;
  logic              wrapped_q, wrapped_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              slot_free;
  logic              fire;

  assign slot_free = !valid_q || inst_ready;
  assign fire      = valid_q && inst_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= ADDR_W'(RESET_PC);
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      wrapped_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      wrapped_q <= wrapped_d;
      count_q   <= count_d;
    end
  end

  // Next-state: redirect has priority over halt, halt over fetch
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    wrapped_d = wrapped_q;
    count_d   = count_q + CNT_W'(fire);

    if (redirect_valid) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      state_d = halt_req ? ST_HALT : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (halt_req) begin
        state_d = ST_HALT;
        if (inst_ready) valid_d = 1'b0;
      end else if (slot_free) begin
        inst_d    = rom_inst;
        inst_pc_d = pc_q;
        valid_d   = 1'b1;
        pc_d      = pc_q + ADDR_W'(1);
        if (pc_q == '1) wrapped_d = 1'b1;
      end
    end else begin
      // Halted: a pending instruction drains on its handshake
      if (inst_ready) valid_d = 1'b0;
    end
  end

  assign rom_address = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign wrapped     = wrapped_q;
  assign fetch_count = count_q;

endmodule
